// File: rtl/rider_steer_ctrl.sv
// Rider-presence / steer-enable FSM. Outputs change two edges after an ld_vld strobe; there is no backpressure, every strobe is taken.
// Optional rider-off debounce is enabled with RIDER_OFF_DEBOUNCE_EN.
module rider_steer_ctrl #(
    parameter int            LD_W         = 12,
    parameter logic [LD_W:0] MIN_RIDER_WT = 'h200,
    parameter logic [LD_W:0] WT_HYST      = 'h40,
    parameter int            LO_SHIFT     = 2,
    parameter int            HI_SHIFT     = 4,
    parameter logic [25:0]   TMR_CYCLES   = 26'd67_108_000,
    parameter int            FAST_SIM     = 1,
    parameter int            OFF_CNT      = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [LD_W-1:0] lft_ld,
    input  logic [LD_W-1:0] rght_ld,
    input  logic            ld_vld,
    output logic            en_steer,
    output logic            rider_off,
    output logic [1:0]      state
);
    localparam logic [25:0]      TMR_TERM   = (FAST_SIM == 1) ? 26'd32767 : TMR_CYCLES;
    localparam int               TMR_W      = $clog2({1'b0, TMR_TERM} + 27'd1);
    localparam logic [TMR_W-1:0] TMR_TERM_W = TMR_TERM[TMR_W-1:0];
    localparam logic [LD_W:0]    SUM_ON_TH  = MIN_RIDER_WT + WT_HYST;
    localparam logic [LD_W:0]    SUM_OFF_TH = MIN_RIDER_WT - WT_HYST;

    generate
        if (OFF_CNT < 1) begin : g_bad_off_cnt
            $error("OFF_CNT must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STEER = 2'd2
    } state_t;

    logic [LD_W-1:0]  r_lft_s, r_rght_s;
    logic [TMR_W-1:0] r_tmr, w_tmr_nxt;
    state_t           r_state, w_state_nxt;
    logic             r_en_steer, r_rider_off;
    logic [LD_W:0]    w_sum, w_abs_diff;
    logic             w_sum_gt_min, w_sum_lt_min, w_diff_gt_lo, w_diff_gt_hi;
    logic             w_tmr_full, w_off_go;

    assign w_sum        = {1'b0, r_lft_s} + {1'b0, r_rght_s};
    assign w_abs_diff   = (r_lft_s >= r_rght_s) ? {1'b0, r_lft_s - r_rght_s}
                                                : {1'b0, r_rght_s - r_lft_s};
    assign w_sum_gt_min = (w_sum > SUM_ON_TH);
    assign w_sum_lt_min = (w_sum < SUM_OFF_TH);
    assign w_diff_gt_lo = (w_abs_diff > (w_sum >> LO_SHIFT));
    assign w_diff_gt_hi = (w_abs_diff > (w_sum - (w_sum >> HI_SHIFT)));
    assign w_tmr_full   = (r_tmr == TMR_TERM_W);

`ifdef RIDER_OFF_DEBOUNCE_EN
    localparam int               CNT_W   = $clog2(OFF_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OFF_CNT);

    logic             r_vld_d;
    logic [CNT_W-1:0] r_off_cnt, w_off_cnt_nxt;

    // r_vld_d marks the cycle in which the registered pair is a fresh sample.
    always_comb begin
        w_off_cnt_nxt = r_off_cnt;
        if (r_vld_d) begin
            if (!w_sum_lt_min)
                w_off_cnt_nxt = '0;
            else if (r_off_cnt != CNT_MAX)
                w_off_cnt_nxt = r_off_cnt + CNT_W'(1);
        end
    end

    assign w_off_go = (w_off_cnt_nxt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_d   <= 1'b0;
            r_off_cnt <= '0;
        end else begin
            r_vld_d   <= ld_vld;
            r_off_cnt <= (w_state_nxt == ST_IDLE) ? '0 : w_off_cnt_nxt;
        end
    end
`else
    assign w_off_go = w_sum_lt_min;
`endif

    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE:  w_state_nxt = w_sum_gt_min ? ST_WAIT : ST_IDLE;
            ST_WAIT: begin
                if (w_off_go)          w_state_nxt = ST_IDLE;
                else if (w_diff_gt_lo) w_state_nxt = ST_WAIT;
                else if (w_tmr_full)   w_state_nxt = ST_STEER;
                else                   w_state_nxt = ST_WAIT;
            end
            ST_STEER: begin
                if (w_off_go)          w_state_nxt = ST_IDLE;
                else if (w_diff_gt_hi) w_state_nxt = ST_WAIT;
                else                   w_state_nxt = ST_STEER;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Timer only runs while staying in WAIT with a balanced load; entry and leaving both zero it.
    always_comb begin
        w_tmr_nxt = r_tmr;
        if ((r_state != ST_WAIT) || (w_state_nxt != ST_WAIT) || w_diff_gt_lo)
            w_tmr_nxt = '0;
        else if (!w_tmr_full)
            w_tmr_nxt = r_tmr + TMR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lft_s     <= '0;
            r_rght_s    <= '0;
            r_state     <= ST_IDLE;
            r_tmr       <= '0;
            r_en_steer  <= 1'b0;
            r_rider_off <= 1'b1;
        end else begin
            if (ld_vld) begin
                r_lft_s  <= lft_ld;
                r_rght_s <= rght_ld;
            end
            r_state     <= w_state_nxt;
            r_tmr       <= w_tmr_nxt;
            r_en_steer  <= (w_state_nxt == ST_STEER);
            r_rider_off <= (w_state_nxt == ST_IDLE);
        end
    end

    assign en_steer  = r_en_steer;
    assign rider_off = r_rider_off;
    assign state     = r_state;

endmodule

// File: tb/tb_rider_steer_ctrl.sv
// Bench for rider_steer_ctrl: randomized and directed load samples, per-cycle scoreboard against a reference model.
// A second instance shares the stimulus and is used only to observe an asynchronous reset taken while steering.
module tb_rider_steer_ctrl;
    localparam int MIN_WT  = 'h200;
    localparam int HYST    = 'h40;
    localparam int TERM    = 32767;
    localparam int OFF_CNT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rst_n_b = 1'b1;
    logic [11:0] lft_ld = '0;
    logic [11:0] rght_ld = '0;
    logic        ld_vld = 1'b0;
    wire         en_steer, rider_off, b_en_steer, b_rider_off;
    wire  [1:0]  state, b_state;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rider_steer_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .lft_ld(lft_ld), .rght_ld(rght_ld), .ld_vld(ld_vld),
        .en_steer(en_steer), .rider_off(rider_off), .state(state)
    );

    rider_steer_ctrl u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .lft_ld(lft_ld), .rght_ld(rght_ld), .ld_vld(ld_vld),
        .en_steer(b_en_steer), .rider_off(b_rider_off), .state(b_state)
    );

    typedef struct {
        logic [1:0] st;
        logic       en;
        logic       off;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: plain integer arithmetic on the last accepted sample pair.
    int m_l, m_r, m_st, m_tmr, m_cnt;
    bit m_vld_d;

    always @(posedge clk or negedge rst_n) begin
        int  sum, diff;
        bit  gt, lt, lo, hi, off_go;
        exp_t e;
        if (!rst_n) begin
            m_l = 0; m_r = 0; m_st = 0; m_tmr = 0; m_cnt = 0; m_vld_d = 0;
            exp_q.delete();
        end else begin
            sum  = m_l + m_r;
            diff = (m_l > m_r) ? m_l - m_r : m_r - m_l;
            gt   = sum > MIN_WT + HYST;
            lt   = sum < MIN_WT - HYST;
            lo   = diff > sum / 4;
            hi   = diff > sum - sum / 16;
`ifdef RIDER_OFF_DEBOUNCE_EN
            if (m_vld_d) m_cnt = lt ? m_cnt + 1 : 0;
            off_go = (m_cnt >= OFF_CNT);
`else
            off_go = lt;
`endif
            if (m_st == 0) begin
                if (gt) begin m_st = 1; m_tmr = 0; end
            end else if (m_st == 1) begin
                if (off_go)             m_st = 0;
                else if (lo)            m_tmr = 0;
                else if (m_tmr == TERM) m_st = 2;
                else                    m_tmr = m_tmr + 1;
            end else begin
                if (off_go)  m_st = 0;
                else if (hi) begin m_st = 1; m_tmr = 0; end
            end
            if (m_st != 1) m_tmr = 0;
            if (m_st == 0) m_cnt = 0;
            m_vld_d = ld_vld;
            if (ld_vld) begin m_l = lft_ld; m_r = rght_ld; end
        end
        e.st  = 2'(m_st);
        e.en  = (m_st == 2);
        e.off = (m_st == 0);
        exp_q.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (state !== e.st || en_steer !== e.en || rider_off !== e.off) begin
                n_bad++;
                if (n_bad <= 20)
                    $display("FAIL scoreboard t=%0t state=%0d want %0d en_steer=%0b want %0b rider_off=%0b want %0b",
                             $time, state, e.st, en_steer, e.en, rider_off, e.off);
            end
        end
    end

    task automatic check(input string name, input int act, input int want);
        n_vec++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, want);
        end
    endtask

    task automatic sample(input logic [11:0] l, input logic [11:0] r);
        @(posedge clk); #1;
        lft_ld = l; rght_ld = r; ld_vld = 1'b1;
        @(posedge clk); #1;
        ld_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2 rst_n = 1'b0; rst_n_b = 1'b0;
        #1;
        check("rst_state", int'(state), 0);
        check("rst_en_steer", int'(en_steer), 0);
        check("rst_rider_off", int'(rider_off), 1);
        idle(3);
        rst_n = 1'b1; rst_n_b = 1'b1;

        repeat (400) begin
            @(posedge clk); #1;
            ld_vld  = 1'($urandom_range(0, 1));
            lft_ld  = 12'($urandom_range(0, 'h3FF));
            rght_ld = 12'($urandom_range(0, 'h3FF));
        end
        ld_vld = 1'b0;
        rst_n = 1'b0; rst_n_b = 1'b0;
        idle(2);
        rst_n = 1'b1; rst_n_b = 1'b1;
        idle(2);

        // Mount, disturb with an uneven load, then rebalance and wait out the settle timer.
        sample(12'h150, 12'h150);
        idle(1);
        check("mount_wait", int'(state), 1);
        check("mount_rider_off", int'(rider_off), 0);
        sample(12'h200, 12'h0A0);
        idle(200);
        check("uneven_no_steer", int'(en_steer), 0);
        sample(12'h150, 12'h150);
        idle(32767);
        check("settle_not_yet", int'(state), 1);
        idle(1);
        check("settle_steer", int'(state), 2);
        check("settle_en_steer", int'(en_steer), 1);

        sample(12'h270, 12'h020);
        idle(3);
        check("diff_250_keeps_steer", int'(state), 2);
        sample(12'h0E0, 12'h0E0);
        idle(3);
        check("sum_1c0_keeps_steer", int'(state), 2);
        repeat (OFF_CNT) sample(12'h0E0, 12'h0DF);
        idle(2);
        check("sum_1bf_idle", int'(state), 0);
        check("sum_1bf_rider_off", int'(rider_off), 1);

        sample(12'h100, 12'h100);
        idle(3);
        check("sum_200_idle", int'(state), 0);
        sample(12'h120, 12'h120);
        idle(3);
        check("sum_240_idle", int'(state), 0);
        sample(12'h121, 12'h120);
        idle(1);
        check("sum_241_wait", int'(state), 1);
        idle(32767);
        check("settle2_not_yet", int'(state), 1);
        idle(1);
        check("settle2_steer", int'(state), 2);

        @(posedge clk); #3;
        check("b_pre_reset_state", int'(b_state), 2);
        rst_n_b = 1'b0;
        #1;
        check("b_async_rst_state", int'(b_state), 0);
        check("b_async_rst_en_steer", int'(b_en_steer), 0);
        check("b_async_rst_rider_off", int'(b_rider_off), 1);

`ifdef RIDER_OFF_DEBOUNCE_EN
        repeat (3) sample(12'h080, 12'h080);
        sample(12'h150, 12'h150);
        idle(2);
        check("debounce_3_low_steer", int'(state), 2);
        repeat (3) sample(12'h080, 12'h080);
        idle(2);
        check("debounce_still_steer", int'(state), 2);
        sample(12'h080, 12'h080);
        idle(1);
        check("debounce_4th_idle", int'(state), 0);
`else
        sample(12'h280, 12'h010);
        idle(1);
        check("imbalance_wait", int'(state), 1);
        check("imbalance_en_steer", int'(en_steer), 0);
`endif
        idle(5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
